fp_compare_pipe: RTL and testbench
==================================

Name: fp_compare_pipe

Overview:
- Parametrised, pipelined floating-point compare/min-max unit. Successor to the single-precision combinational comparator.
- Supports configurable exponent and fraction widths and five operations: FEQ, FLT, FLE, FMIN, FMAX.
- Has a two-stage valid/ready pipeline with tag passthrough.
- Sits in the FP execution block, between the issue port and the writeback arbiter.

Parameters:
- EXP_W, 8: exponent field width.
- FRAC_W, 23: fraction field width (hidden bit excluded). Operand width W = 1+EXP_W+FRAC_W.
- TAG_W, 6: width of the opaque tag carried alongside each operation.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- in_valid  in  1  operation present on the input.
- in_ready  out  1  unit accepts the input this cycle.
- in_op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX; 101-111 reserved.
- in_a  in  W  operand a.
- in_b  in  W  operand b.
- in_tag  in  TAG_W  tag; returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  W  compare ops: {W-1 zeros, bool}; min/max: the selected value.
- out_fflags  out  5  {NV,DZ,OF,UF,NX}. Only NV is ever set; the other four bits are always 0.
- out_tag  out  TAG_W  tag of the returned result.

Behaviour:
- Reset (reset=0, asynchronous): both stage valid bits clear.
  - out_valid=0; out_result, out_fflags and out_tag = 0.
  - in_ready goes high on the first cycle after reset deasserts.
- Pipeline: S1 and S2 registers; latency is exactly 2 cycles from input handshake to out_valid with no backpressure.
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances into S2 under the same condition.
  - in_ready = !S1.valid | S2 loads this cycle. No combinational path from in_valid to out_*.
  - Full throughput: 1 operation per cycle while out_ready=1.
  - With out_ready=0 and both stages full, in_ready=0. Held outputs stay stable until the handshake completes.
  - When an output retires and a new input enters in the same cycle, both stages advance; no bubble is inserted.
- S1 work:
  - Field decode: isZero, isNaN, isSNaN (exp all ones, frac≠0, frac MSB=0), sign.
  - (W+1)-bit unsigned subtract a−b; register the decoded flags, uint_eq and the borrow.
- S2 work: result and flag select.
- Ordering (equivalent to the existing single-precision comparator):
  - eq = !hasNaN & (uint_eq | bothZero).
  - Same sign: lt = !hasNaN & (sign_a ^ borrow) & !uint_eq.
  - Different sign: lt = !hasNaN & sign_a & !bothZero.
  - le = lt | eq.
- NV rules:
  - FEQ: NV = hasSNaN.
  - FLT/FLE: NV = hasNaN (signaling).
  - FMIN/FMAX: NV = hasSNaN.
- FMIN/FMAX operand selection:
  - Both NaN: return the canonical NaN {0, all-ones exp, 1, zeros}.
  - Exactly one NaN: return the other operand.
  - Otherwise: return the smaller value for FMIN, the larger for FMAX.
  - Zero ordering for min/max: −0 < +0. FMIN(+0,−0)=−0; FMAX(+0,−0)=+0.
  - Equal non-zero values: return a.
- Reserved op: out_result=0, out_fflags=0, still returns with its tag (no hang).
- Reset mid-operation: in-flight operations are discarded and no output is produced for them.

Optional Feature:
- Macro: FP_COMPARE_PIPE_FCLASS_EN.
- Defined: op 101 = FCLASS of a (b ignored).
  - out_result = one-hot 10-bit RISC-V class mask, zero-extended to W. Bits 0..9: −inf, −normal, −subnormal, −0, +0, +subnormal, +normal, +inf, sNaN, qNaN.
  - fflags = 0 for FCLASS; latency unchanged.
- Undefined: op 101 is reserved and behaves as other reserved ops.

Test Plan:
- FLT, a=0x3F800000, b=0x40000000, out_ready=1 -> out_result=1, fflags=0, out_valid exactly 2 cycles after the input handshake.
- FEQ, a=0x00000000, b=0x80000000 -> result 1, fflags 0. FLE with a=0x7FC00000 -> result 0, fflags=0x10.
- FEQ, a=0x7F800001 (sNaN), b=0x3F800000 -> result 0, fflags=0x10. FMIN of the same operands -> result 0x3F800000, fflags=0x10.
- FMAX, a=0x7FC00000, b=0x7FA00000 -> result 0x7FC00000, fflags=0x10. FMIN(0x00000000, 0x80000000) -> 0x80000000.
- Back-to-back 8 ops, tags 0..7, out_ready low cycles 3-6:
  - in_ready drops when both stages are full.
  - Results emerge in tag order 0..7 with no loss or duplication.
  - Outputs are held stable while stalled.
- EXP_W=11, FRAC_W=52 instance: FLT(0xBFF0000000000000, 0x3FF0000000000000) -> 1.
- Reset asserted while 2 ops are in flight -> out_valid=0 immediately and no stale result after release.
- With FP_COMPARE_PIPE_FCLASS_EN: op 101, a=0xFF800000 -> 0x001.

Source files
------------

// File: rtl/fp_compare_pipe_if.sv
// Handshake bundle for fp_compare_pipe: issue side in_*, writeback side out_*.
// Master drives operations and consumes results; slave is the unit.
interface fp_compare_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 6
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [4:0]       out_fflags;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_fflags, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_fflags, out_tag
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage FP compare / min-max: S1 decodes + subtracts, S2 selects.
// FP_COMPARE_PIPE_FCLASS_EN enables op 101 as FCLASS of operand a.
module fp_compare_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 6
) (
  input  logic            clock,
  input  logic            reset,
  fp_compare_pipe_if.slave io
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [W-1:0] CANON_NAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             a_zero;
    logic             b_zero;
    logic             a_nan;
    logic             b_nan;
    logic             a_snan;
    logic             b_snan;
    logic             uint_eq;
    logic             borrow;
`ifdef FP_COMPARE_PIPE_FCLASS_EN
    logic [9:0]       cls;
`endif
  } s1_t;

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s2_valid;
  logic [W-1:0]     s2_result;
  logic [4:0]       s2_fflags;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_load;

  logic [EXP_W-1:0]  exp_a;
  logic [EXP_W-1:0]  exp_b;
  logic [FRAC_W-1:0] frac_a;
  logic [FRAC_W-1:0] frac_b;
  logic [W:0]        diff;

`ifdef FP_COMPARE_PIPE_FCLASS_EN
  logic inf_a;
  logic sub_a;
  logic norm_a;
  logic neg_a;
`endif

  logic         has_nan;
  logic         has_snan;
  logic         both_zero;
  logic         sign_a;
  logic         sign_b;
  logic         eq;
  logic         lt;
  logic         le;
  logic         lt_mm;
  logic [W-1:0] res_d;
  logic         nv_d;

  assign s2_load     = !s2_valid | io.out_ready;
  assign io.in_ready = !s1_q.valid | s2_load;

  // S1: field decode and (W+1)-bit magnitude subtract
  always_comb begin
    exp_a  = io.in_a[W-2 -: EXP_W];
    exp_b  = io.in_b[W-2 -: EXP_W];
    frac_a = io.in_a[FRAC_W-1:0];
    frac_b = io.in_b[FRAC_W-1:0];
    diff   = {1'b0, io.in_a} - {1'b0, io.in_b};
    s1_d         = '0;
    s1_d.valid   = io.in_valid;
    s1_d.op      = io.in_op;
    s1_d.tag     = io.in_tag;
    s1_d.a       = io.in_a;
    s1_d.b       = io.in_b;
    s1_d.a_zero  = ~|io.in_a[W-2:0];
    s1_d.b_zero  = ~|io.in_b[W-2:0];
    s1_d.a_nan   = (&exp_a) & (|frac_a);
    s1_d.b_nan   = (&exp_b) & (|frac_b);
    s1_d.a_snan  = s1_d.a_nan & ~frac_a[FRAC_W-1];
    s1_d.b_snan  = s1_d.b_nan & ~frac_b[FRAC_W-1];
    s1_d.uint_eq = ~|diff[W-1:0];
    s1_d.borrow  = diff[W];
`ifdef FP_COMPARE_PIPE_FCLASS_EN
    inf_a  = (&exp_a) & ~|frac_a;
    sub_a  = ~|exp_a & |frac_a;
    norm_a = ~&exp_a & |exp_a;
    neg_a  = io.in_a[W-1];
    s1_d.cls = {
      s1_d.a_nan & ~s1_d.a_snan,
      s1_d.a_snan,
      ~neg_a & inf_a,
      ~neg_a & norm_a,
      ~neg_a & sub_a,
      ~neg_a & s1_d.a_zero,
      neg_a & s1_d.a_zero,
      neg_a & sub_a,
      neg_a & norm_a,
      neg_a & inf_a
    };
`endif
  end

  // S2: ordering, result and NV select
  always_comb begin
    has_nan   = s1_q.a_nan | s1_q.b_nan;
    has_snan  = s1_q.a_snan | s1_q.b_snan;
    both_zero = s1_q.a_zero & s1_q.b_zero;
    sign_a    = s1_q.a[W-1];
    sign_b    = s1_q.b[W-1];
    eq = !has_nan & (s1_q.uint_eq | both_zero);
    if (sign_a == sign_b)
      lt = !has_nan & (sign_a ^ s1_q.borrow) & !s1_q.uint_eq;
    else
      lt = !has_nan & sign_a & !both_zero;
    le    = lt | eq;
    lt_mm = lt | (both_zero & sign_a & !sign_b);
    res_d = '0;
    nv_d  = 1'b0;
    case (s1_q.op)
      3'b000: begin
        res_d = {{(W-1){1'b0}}, eq};
        nv_d  = has_snan;
      end
      3'b001: begin
        res_d = {{(W-1){1'b0}}, lt};
        nv_d  = has_nan;
      end
      3'b010: begin
        res_d = {{(W-1){1'b0}}, le};
        nv_d  = has_nan;
      end
      3'b011: begin
        nv_d = has_snan;
        if (s1_q.a_nan & s1_q.b_nan) res_d = CANON_NAN;
        else if (s1_q.a_nan)         res_d = s1_q.b;
        else if (s1_q.b_nan)         res_d = s1_q.a;
        else if (lt_mm | s1_q.uint_eq) res_d = s1_q.a;
        else                         res_d = s1_q.b;
      end
      3'b100: begin
        nv_d = has_snan;
        if (s1_q.a_nan & s1_q.b_nan) res_d = CANON_NAN;
        else if (s1_q.a_nan)         res_d = s1_q.b;
        else if (s1_q.b_nan)         res_d = s1_q.a;
        else if (lt_mm)              res_d = s1_q.b;
        else                         res_d = s1_q.a;
      end
`ifdef FP_COMPARE_PIPE_FCLASS_EN
      3'b101: res_d = {{(W-10){1'b0}}, s1_q.cls};
`endif
      default: res_d = '0;
    endcase
  end

  // S1 register: loads whenever the unit accepts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s1_q <= '0;
    else if (io.in_ready) s1_q <= s1_d;
  end

  // S2 register: holds while the consumer stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_fflags <= '0;
      s2_tag    <= '0;
    end else if (s2_load) begin
      s2_valid  <= s1_q.valid;
      s2_result <= res_d;
      s2_fflags <= {nv_d, 4'b0000};
      s2_tag    <= s1_q.tag;
    end
  end

  assign io.out_valid  = s2_valid;
  assign io.out_result = s2_result;
  assign io.out_fflags = s2_fflags;
  assign io.out_tag    = s2_tag;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: directed vectors, value-ordering model,
// per-cycle output scoreboard, stall/reset/double-precision cases.
module tb_fp_compare_pipe;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fp_compare_pipe_if #(.EXP_W(8), .FRAC_W(23), .TAG_W(6)) bus ();
  fp_compare_pipe_if #(.EXP_W(11), .FRAC_W(52), .TAG_W(6)) bus64 ();

  fp_compare_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(6)) dut (
    .clock(clock), .reset(reset), .io(bus)
  );
  fp_compare_pipe #(.EXP_W(11), .FRAC_W(52), .TAG_W(6)) dut64 (
    .clock(clock), .reset(reset), .io(bus64)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [5:0]  tag;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  exp_t expq[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errs = 0;
  int   pops = 0;
  bit   saw_block = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: order by signed magnitude key, NaN and zero rules explicit
  function automatic exp_t model32(input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [5:0] tag);
    exp_t   r;
    bit     an, bn, asn, bsn, nv;
    longint ka, kb;
    int     idx;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ka  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb  = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    r.res = 0;
    r.tag = tag;
    nv = 0;
    case (op)
      3'd0: begin r.res = {31'd0, !(an || bn) && ka == kb}; nv = asn || bsn; end
      3'd1: begin r.res = {31'd0, !(an || bn) && ka < kb}; nv = an || bn; end
      3'd2: begin r.res = {31'd0, !(an || bn) && ka <= kb}; nv = an || bn; end
      3'd3, 3'd4: begin
        nv = asn || bsn;
        if (an && bn) r.res = 32'h7FC00000;
        else if (an) r.res = b;
        else if (bn) r.res = a;
        else if (ka < kb) r.res = (op == 3'd3) ? a : b;
        else if (ka > kb) r.res = (op == 3'd3) ? b : a;
        else if (a != b) r.res = ((op == 3'd3) == a[31]) ? a : b;
        else r.res = a;
      end
`ifdef FP_COMPARE_PIPE_FCLASS_EN
      3'd5: begin
        if (an) idx = asn ? 8 : 9;
        else if (a[30:23] == 8'hFF) idx = a[31] ? 0 : 7;
        else if (a[30:0] == 0) idx = a[31] ? 3 : 4;
        else if (a[30:23] == 0) idx = a[31] ? 2 : 5;
        else idx = a[31] ? 1 : 6;
        r.res = 32'd1 << idx;
      end
`endif
      default: r.res = 0;
    endcase
    r.fl = {nv, 4'b0000};
    return r;
  endfunction

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic [4:0] fl);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl;
    vecs.push_back(v);
  endtask

  // Scoreboard: capture accepted inputs, check every retired/held output
  logic        stall_q = 0;
  logic [31:0] held_res;
  logic [4:0]  held_fl;
  logic [5:0]  held_tag;
  exp_t        e_m;
  always @(negedge clock) begin
    if (!reset) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_result", bus.out_result, held_res);
        chk("hold_fflags", bus.out_fflags, held_fl);
        chk("hold_tag", bus.out_tag, held_tag);
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model32(bus.in_op, bus.in_a, bus.in_b, bus.in_tag));
      if (bus.in_valid && !bus.in_ready) saw_block = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL spurious_out: got tag %h, want no output", bus.out_tag);
        end else begin
          e_m = expq.pop_front();
          pops++;
          chk("out_result", bus.out_result, e_m.res);
          chk("out_fflags", bus.out_fflags, e_m.fl);
          chk("out_tag", bus.out_tag, e_m.tag);
        end
      end
      stall_q  = bus.out_valid && !bus.out_ready;
      held_res = bus.out_result;
      held_fl  = bus.out_fflags;
      held_tag = bus.out_tag;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] tag);
    int n;
    n = 0;
    bus.in_valid = 1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    bus.in_tag = tag;
    @(negedge clock);
    while (!bus.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got in_ready 0, want 1 for tag %h", tag);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(name, expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0;
    bus.in_tag = 0; bus.out_ready = 1;
    bus64.in_valid = 0; bus64.in_op = 0; bus64.in_a = 0; bus64.in_b = 0;
    bus64.in_tag = 0; bus64.out_ready = 1;

    add_vec(3'd1, 32'h3F800000, 32'h40000000, 32'h1, 5'h00);
    add_vec(3'd0, 32'h00000000, 32'h80000000, 32'h1, 5'h00);
    add_vec(3'd2, 32'h7FC00000, 32'h3F800000, 32'h0, 5'h10);
    add_vec(3'd0, 32'h7F800001, 32'h3F800000, 32'h0, 5'h10);
    add_vec(3'd3, 32'h7F800001, 32'h3F800000, 32'h3F800000, 5'h10);
    add_vec(3'd4, 32'h7FC00000, 32'h7FA00000, 32'h7FC00000, 5'h10);
    add_vec(3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 5'h00);
    add_vec(3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 5'h00);
    add_vec(3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 5'h00);
    add_vec(3'd1, 32'hBF800000, 32'h3F800000, 32'h1, 5'h00);
    add_vec(3'd1, 32'hC0000000, 32'hBF800000, 32'h1, 5'h00);
    add_vec(3'd1, 32'hBF800000, 32'hC0000000, 32'h0, 5'h00);
    add_vec(3'd2, 32'h3F800000, 32'h3F800000, 32'h1, 5'h00);
    add_vec(3'd0, 32'h7FC00000, 32'h7FC00000, 32'h0, 5'h00);
    add_vec(3'd1, 32'h80000000, 32'h00000000, 32'h0, 5'h00);
    add_vec(3'd1, 32'h80000001, 32'h00000001, 32'h1, 5'h00);
    add_vec(3'd4, 32'h3F800000, 32'h40000000, 32'h40000000, 5'h00);
    add_vec(3'd3, 32'hC0000000, 32'hBF800000, 32'hC0000000, 5'h00);
    add_vec(3'd3, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 5'h00);
    add_vec(3'd7, 32'h3F800000, 32'h40000000, 32'h0, 5'h00);
`ifdef FP_COMPARE_PIPE_FCLASS_EN
    add_vec(3'd5, 32'hFF800000, 32'h12345678, 32'h1, 5'h00);
    add_vec(3'd5, 32'h7F800001, 32'h0, 32'h100, 5'h00);
`else
    add_vec(3'd5, 32'hFF800000, 32'h12345678, 32'h0, 5'h00);
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_result", bus.out_result, 0);
    chk("reset_out_fflags", bus.out_fflags, 0);
    chk("reset_out_tag", bus.out_tag, 0);
    @(posedge clock);
    #1;
    reset = 1;
    chk("in_ready_after_reset", bus.in_ready, 1);

    foreach (vecs[i]) begin
      e_m = model32(vecs[i].op, vecs[i].a, vecs[i].b, 6'd0);
      chk($sformatf("model_res_%0d", i), e_m.res, vecs[i].res);
      chk($sformatf("model_fl_%0d", i), e_m.fl, vecs[i].fl);
    end

    send(3'd1, 32'h3F800000, 32'h40000000, 6'd40);
    chk("latency_not_early", bus.out_valid, 0);
    @(posedge clock);
    #1;
    chk("latency_two_cycles", bus.out_valid, 1);
    chk("latency_result", bus.out_result, 1);
    drain("drain_latency");

    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, 6'(i));
    drain("drain_vectors");

    pops = 0;
    saw_block = 0;
    fork
      for (int t = 0; t < 8; t++)
        send(3'(t % 5), 32'h3F800000 + 32'(t * 3), 32'h3F800008, 6'(t));
      begin
        for (int c = 0; c < 14; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          @(posedge clock);
          #1;
        end
        bus.out_ready = 1;
      end
    join
    drain("drain_burst");
    chk("burst_count", pops, 8);
    chk("burst_in_ready_dropped", saw_block, 1);

    bus.out_ready = 0;
    send(3'd1, 32'h3F800000, 32'h40000000, 6'd50);
    send(3'd4, 32'h3F800000, 32'h40000000, 6'd51);
    chk("preflush_valid", bus.out_valid, 1);
    reset = 0;
    #1;
    chk("reset_kills_valid", bus.out_valid, 0);
    expq.delete();
    @(posedge clock);
    #1;
    reset = 1;
    bus.out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      chk("no_stale_after_reset", bus.out_valid, 0);
    end

    bus64.in_valid = 1; bus64.in_op = 3'd1;
    bus64.in_a = 64'hBFF0000000000000; bus64.in_b = 64'h3FF0000000000000;
    bus64.in_tag = 6'd7;
    @(negedge clock);
    chk("d64_in_ready", bus64.in_ready, 1);
    @(posedge clock);
    #1;
    bus64.in_op = 3'd3;
    bus64.in_a = 64'h3FF0000000000000; bus64.in_b = 64'hBFF0000000000000;
    bus64.in_tag = 6'd8;
    @(posedge clock);
    #1;
    bus64.in_valid = 0;
    chk("d64_valid", bus64.out_valid, 1);
    chk("d64_flt", bus64.out_result, 64'h1);
    chk("d64_tag", bus64.out_tag, 7);
    @(posedge clock);
    #1;
    chk("d64_fmin", bus64.out_result, 64'hBFF0000000000000);
    chk("d64_tag2", bus64.out_tag, 8);
    @(posedge clock);
    #1;
    chk("d64_idle", bus64.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
